// File: rtl/lsu.sv
// rv32i load/store unit: aligned byte-enabled stores, extended loads, valid/ready memory port.
// Optional bus timeout is enabled with `define LSU_TIMEOUT_EN.
module lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  func_3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        fault,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state;
    state_t      state_n;
    logic        we_r;
    logic [2:0]  f3_r;
    logic [1:0]  off_r;
    logic        fault_r;
    logic        legal;
    logic        timeout;
    logic [3:0]  be_c;
    logic [31:0] wd_c;
    logic [31:0] ext;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

`ifdef LSU_TIMEOUT_EN
    logic [15:0] cnt;
    assign timeout = (state == BUSY) && !mem_ready
                     && (cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        legal = 1'b0;
        case (func_3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~addr[0];
            3'b010:  legal = (addr[1:0] == 2'b00);
            3'b100:  legal = ~req_we;
            3'b101:  legal = ~req_we & ~addr[0];
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        be_c = 4'b1111;
        wd_c = wdata;
        case (func_3[1:0])
            2'b00: begin
                be_c = 4'b0001 << addr[1:0];
                wd_c = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_c = 4'b0011 << addr[1:0];
                wd_c = {2{wdata[15:0]}};
            end
            default: begin
                be_c = 4'b1111;
                wd_c = wdata;
            end
        endcase
    end

    // Lane selection uses the offset latched at request time.
    assign rbyte = 8'(mem_rdata >> {off_r, 3'b000});
    assign rhalf = off_r[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        ext = mem_rdata;
        case (f3_r)
            3'b000:  ext = {{24{rbyte[7]}}, rbyte};
            3'b001:  ext = {{16{rhalf[15]}}, rhalf};
            3'b100:  ext = {24'h0, rbyte};
            3'b101:  ext = {16'h0, rhalf};
            default: ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (req_valid) state_n = legal ? BUSY : RESP;
            BUSY: if (mem_ready || timeout) state_n = RESP;
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            we_r      <= 1'b0;
            f3_r      <= 3'b000;
            off_r     <= 2'b00;
            fault_r   <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'h0;
            load_data <= 32'h0;
        end else begin
            state <= state_n;
            if (state == IDLE && req_valid) begin
                fault_r <= ~legal;
                if (legal) begin
                    we_r      <= req_we;
                    f3_r      <= func_3;
                    off_r     <= addr[1:0];
                    mem_addr  <= {addr[31:2], 2'b00};
                    mem_be    <= be_c;
                    mem_wdata <= wd_c;
                end
            end
            if (state == BUSY && mem_ready && !we_r)
                load_data <= ext;
            if (timeout)
                fault_r <= 1'b1;
        end
    end

`ifdef LSU_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst || state != BUSY)
            cnt <= 16'h0;
        else if (!mem_ready)
            cnt <= cnt + 16'h1;
    end
`endif

    assign mem_valid = (state == BUSY);
    assign mem_we    = mem_valid & we_r;
    assign done      = (state == RESP);
    assign fault     = done & fault_r;
    assign stall     = req_valid & (state != RESP);

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed table, reset abort, randomized vs. model.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  func_3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic        fault;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad = 0;
    logic [31:0] ld_shadow;

    always #5 clk = ~clk;

    lsu dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .func_3(func_3), .addr(addr), .wdata(wdata), .stall(stall),
        .done(done), .load_data(load_data), .fault(fault),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        int          dly;
        logic        xf;
        logic [3:0]  xbe;
        logic [31:0] xwd;
        logic [31:0] xld;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string n, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    // Reference model straight from the access rules.
    function automatic logic m_legal(input logic we, input logic [2:0] f3,
                                     input logic [31:0] a);
        int sz;
        logic ok;
        ok = we ? (f3 < 3) : (f3 != 3 && f3 < 6);
        sz = 1 << f3[1:0];
        return ok && ((a % sz) == 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3,
                                        input logic [31:0] a);
        int sz;
        sz = 1 << f3[1:0];
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] f3,
                                         input logic [31:0] wd);
        if (f3[1:0] == 2'd0) return {24'h0, wd[7:0]} * 32'h01010101;
        if (f3[1:0] == 2'd1) return {16'h0, wd[15:0]} * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_ld(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] rd);
        logic [63:0] v;
        int bits;
        bits = 8 * (1 << f3[1:0]);
        v = 64'(rd >> (8 * (a % 4)));
        v = v & ((64'd1 << bits) - 64'd1);
        if (!f3[2] && bits < 32 && v[bits-1])
            v = v - (64'd1 << bits);
        return v[31:0];
    endfunction

    task automatic run(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int dly,
                       input logic xf, input logic [3:0] xbe,
                       input logic [31:0] xwd, input logic [31:0] xld);
        int busy = 0;
        int cyc = 0;
        bit seen = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we = we;
        func_3 = f3;
        addr = a;
        wdata = wd;
        mem_rdata = rd;
        mem_ready = 1'b0;
        #1 check("stall_req", 32'(stall), 32'd1);
        while (!seen && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                seen = 1;
                check("fault", 32'(fault), 32'(xf));
                check("stall_resp", 32'(stall), 32'd0);
                if (!we && !xf) ld_shadow = xld;
                check("load_data", load_data, ld_shadow);
            end else if (mem_valid) begin
                busy++;
                check("mem_addr", mem_addr, {a[31:2], 2'b00});
                check("mem_be", 32'(mem_be), 32'(xbe));
                check("mem_we", 32'(mem_we), 32'(we));
                if (we) check("mem_wdata", mem_wdata, xwd);
                check("stall_busy", 32'(stall), 32'd1);
                mem_ready = (busy > dly);
            end else begin
                check("no_progress", 32'(cyc), 32'd0);
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        check("busy_cycles", 32'(busy), xf ? 32'd0 : 32'(dly + 1));
        req_valid = 1'b0;
        mem_ready = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0,
                    0, 4'b1111, 32'h0, 32'hDEADBEEF};
        tbl[1]  = '{0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0,
                    0, 4'b1000, 32'h0, 32'hFFFFFF80};
        tbl[2]  = '{0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 1,
                    0, 4'b1000, 32'h0, 32'h00000080};
        tbl[3]  = '{1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 0,
                    0, 4'b1100, 32'hABCDABCD, 32'h0};
        tbl[4]  = '{0, 3'b010, 32'h101, 32'h0, 32'h12345678, 0,
                    1, 4'b0000, 32'h0, 32'h0};
        tbl[5]  = '{0, 3'b001, 32'h002, 32'h0, 32'h80017FFF, 2,
                    0, 4'b1100, 32'h0, 32'hFFFF8001};
        tbl[6]  = '{0, 3'b101, 32'h002, 32'h0, 32'h80017FFF, 0,
                    0, 4'b1100, 32'h0, 32'h00008001};
        tbl[7]  = '{1, 3'b000, 32'h301, 32'h000000AB, 32'h0, 0,
                    0, 4'b0010, 32'hABABABAB, 32'h0};
        tbl[8]  = '{1, 3'b010, 32'h010, 32'hCAFEF00D, 32'h0, 3,
                    0, 4'b1111, 32'hCAFEF00D, 32'h0};
        tbl[9]  = '{0, 3'b011, 32'h000, 32'h0, 32'h0, 0,
                    1, 4'b0000, 32'h0, 32'h0};
        tbl[10] = '{1, 3'b100, 32'h000, 32'h0, 32'h0, 0,
                    1, 4'b0000, 32'h0, 32'h0};
        tbl[11] = '{1, 3'b001, 32'h001, 32'h0, 32'h0, 0,
                    1, 4'b0000, 32'h0, 32'h0};

        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        func_3 = 3'b000;
        addr = 32'h0;
        wdata = 32'h0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_mvalid", 32'(mem_valid), 32'd0);
        check("rst_mwe", 32'(mem_we), 32'd0);
        check("rst_be", 32'(mem_be), 32'd0);
        check("rst_ld", load_data, 32'h0);
        check("rst_maddr", mem_addr, 32'h0);
        check("rst_mwd", mem_wdata, 32'h0);
        rst = 1'b0;
        ld_shadow = 32'h0;

        for (int i = 0; i < 12; i++)
            run(tbl[i].we, tbl[i].f3, tbl[i].a, tbl[i].wd, tbl[i].rd,
                tbl[i].dly, tbl[i].xf, tbl[i].xbe, tbl[i].xwd, tbl[i].xld);

        // Reset in the middle of a stalled load aborts it silently.
        @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b0;
        func_3 = 3'b010;
        addr = 32'h440;
        mem_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("abort_busy", 32'(mem_valid), 32'd1);
        end
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("abort_mvalid", 32'(mem_valid), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        rst = 1'b0;
        ld_shadow = 32'h0;
        repeat (3) begin
            @(negedge clk);
            check("abort_quiet", 32'({done, mem_valid}), 32'd0);
        end

        // req_valid dropping mid-BUSY must not abort the transfer.
        @(negedge clk);
        req_valid = 1'b1;
        func_3 = 3'b010;
        addr = 32'h500;
        mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        req_valid = 1'b0;
        check("drop_busy", 32'(mem_valid), 32'd1);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        check("drop_done", 32'(done), 32'd1);
        check("drop_ld", load_data, 32'h55AA55AA);
        ld_shadow = 32'h55AA55AA;

        for (int i = 0; i < 200; i++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] wd;
            logic [31:0] rd;
            logic        lg;
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a = $urandom;
            wd = $urandom;
            rd = $urandom;
            lg = m_legal(we, f3, a);
            run(we, f3, a, wd, rd, $urandom_range(0, 3), !lg,
                m_be(f3, a), m_wd(f3, wd), m_ld(f3, a, rd));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
